indicator_driver: RTL and testbench

Four-channel output indicator driver for the vending machine front panel. It is the output-side counterpart of the key debouncer. The debouncer turns a long, noisy press into a single-cycle pulse; this block turns a single-cycle event pulse from the control FSM into a clean, fixed-length level. Typical events are coin accepted, candy dispensed, change returned and error. The level is long enough to drive a visible LED or a dispense solenoid. It sits between the vending FSM and the board's output pins.

---
 rtl/indicator_pkg.sv | 19 +
 rtl/indicator_driver_pulse_stretcher.sv | 72 +++++++
 rtl/indicator_driver.sv | 50 +++++
 tb/tb_indicator_driver.sv | 131 +++++++++++++
 4 files changed

// File: rtl/indicator_pkg.sv
// ============================================================================
// Module   : indicator_pkg
// Brief    : Shared channel-state encoding and channel count for indicator_driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package indicator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } ch_state_t;

    localparam int NUM_CH = 4;

endpackage

`default_nettype wire

// File: rtl/indicator_driver_pulse_stretcher.sv
// ============================================================================
// Module   : pulse_stretcher
// Brief    : One indicator channel; stretches a 1-cycle trigger into a
//            HOLD_CYCLES-long level. Mid-hold retrigger via INDICATOR_RETRIGGER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_stretcher
    import indicator_pkg::*;
#(
    parameter int HOLD_CYCLES = 25000000,
    parameter int CNT_W       = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic trig,
    output logic level,
    output logic level_d
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = HOLD;
                    cnt_d   = RELOAD;
                end
            end
            HOLD: begin
                // Terminal-cycle trigger reloads so back-to-back events leave no gap.
                if (cnt_q == '0) begin
                    if (trig) cnt_d   = RELOAD;
                    else      state_d = IDLE;
                end else begin
`ifdef INDICATOR_RETRIGGER_EN
                    cnt_d = trig ? RELOAD : (cnt_q - CNT_W'(1));
`else
                    cnt_d = cnt_q - CNT_W'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level   = (state_q == HOLD);
    assign level_d = (state_d == HOLD);

endmodule

`default_nettype wire

// File: rtl/indicator_driver.sv
// ============================================================================
// Module   : indicator_driver
// Brief    : Four independent pulse stretchers plus a registered busy flag.
//            Optional mid-hold retrigger: define INDICATOR_RETRIGGER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module indicator_driver
    import indicator_pkg::*;
#(
    parameter int HOLD_CYCLES = 25000000,
    parameter int CNT_W       = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] pulse_in,
    output logic [NUM_CH-1:0] ind_out,
    output logic              busy
);

    logic [NUM_CH-1:0] level_w;
    logic [NUM_CH-1:0] level_d_w;
    logic              busy_q;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        pulse_stretcher #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .CNT_W       (CNT_W)
        ) u_stretch (
            .clk     (clk),
            .reset   (reset),
            .trig    (pulse_in[gi]),
            .level   (level_w[gi]),
            .level_d (level_d_w[gi])
        );
    end

    // Built from the channels' next state so busy tracks OR(ind_out) with no lag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy_q <= 1'b0;
        else        busy_q <= |level_d_w;
    end

    assign ind_out = level_w;
    assign busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_indicator_driver.sv
// ============================================================================
// Module   : tb_indicator_driver
// Brief    : Directed self-checking bench for indicator_driver (HOLD_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_indicator_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] pulse_in = 4'h0;
    logic [3:0] ind_out;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    indicator_driver #(
        .HOLD_CYCLES (4),
        .CNT_W       (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pulse_in (pulse_in),
        .ind_out  (ind_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] e_ind, input logic e_busy);
        vectors++;
        assert (ind_out === e_ind) else begin
            miscompares++;
            $error("FAIL %s ind_out observed=%b expected=%b", tag, ind_out, e_ind);
        end
        vectors++;
        assert (busy === e_busy) else begin
            miscompares++;
            $error("FAIL %s busy observed=%b expected=%b", tag, busy, e_busy);
        end
    endtask

    // Drive pulse for the coming edge, then check outputs just after it.
    task automatic tick(input string tag, input logic [3:0] p, input logic [3:0] e_ind);
        pulse_in = p;
        @(posedge clk);
        #1;
        check(tag, e_ind, |e_ind);
    endtask

    task automatic run(input string tag, input int n,
                       input logic [3:0] p [16], input logic [3:0] e [16]);
        for (int j = 0; j < n; j++) tick($sformatf("%s[c%0d]", tag, j + 1), p[j], e[j]);
        pulse_in = 4'h0;
    endtask

    logic [3:0] p [16];
    logic [3:0] e [16];

    initial begin
        // Reset held with all triggers asserted.
        reset    = 1'b0;
        pulse_in = 4'hF;
        #1;
        check("rst_async", 4'h0, 1'b0);
        for (int j = 0; j < 3; j++) tick("rst_hold", 4'hF, 4'h0);
        pulse_in = 4'h0;
        reset    = 1'b1;

        // First pulse after release: 4 cycles high.
        p = '{default: 4'h0}; e = '{default: 4'h0};
        p[0] = 4'b0001;
        for (int j = 0; j < 4; j++) e[j] = 4'b0001;
        run("rst_release", 6, p, e);

        // Independent channels: bit1 at c0, bit3 at c2.
        p = '{default: 4'h0}; e = '{default: 4'h0};
        p[0] = 4'b0010; p[2] = 4'b1000;
        e[0] = 4'b0010; e[1] = 4'b0010; e[2] = 4'b1010; e[3] = 4'b1010;
        e[4] = 4'b1000; e[5] = 4'b1000;
        run("indep", 8, p, e);

        // Terminal-cycle retrigger: continuous high cycles 1..8.
        p = '{default: 4'h0}; e = '{default: 4'h0};
        p[0] = 4'b0100; p[4] = 4'b0100;
        for (int j = 0; j < 8; j++) e[j] = 4'b0100;
        run("terminal", 10, p, e);

        // Mid-hold trigger at c2.
        p = '{default: 4'h0}; e = '{default: 4'h0};
        p[0] = 4'b0001; p[2] = 4'b0001;
`ifdef INDICATOR_RETRIGGER_EN
        for (int j = 0; j < 6; j++) e[j] = 4'b0001;
`else
        for (int j = 0; j < 4; j++) e[j] = 4'b0001;
`endif
        run("midhold", 8, p, e);

        // Input held high for 10 cycles.
        p = '{default: 4'h0}; e = '{default: 4'h0};
        for (int j = 0; j < 10; j++) p[j] = 4'b0001;
`ifdef INDICATOR_RETRIGGER_EN
        for (int j = 0; j < 13; j++) e[j] = 4'b0001;
`else
        for (int j = 0; j < 12; j++) e[j] = 4'b0001;
`endif
        run("held", 15, p, e);

        // Reset mid-hold: outputs drop asynchronously, hold is discarded.
        tick("rstmid_c1", 4'b1000, 4'b1000);
        tick("rstmid_c2", 4'b0000, 4'b1000);
        #2;
        reset = 1'b0;
        #1;
        check("rstmid_async", 4'h0, 1'b0);
        tick("rstmid_low", 4'h0, 4'h0);
        reset = 1'b1;
        for (int j = 0; j < 5; j++) tick("rstmid_after", 4'h0, 4'h0);
        tick("rstmid_new", 4'b1000, 4'b1000);
        for (int j = 0; j < 3; j++) tick("rstmid_newhold", 4'h0, 4'b1000);
        tick("rstmid_newend", 4'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
